// File: rtl/vital_threshold_scheduler_pkg.sv
// Shared types and constants for the vital-sign threshold scheduler:
// FSM encoding, datapath widths, threshold reset values and the debounce counter helper.
package vital_threshold_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMP_LO = 2'd1,
        ST_CMP_HI = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int SAMPLE_W = 8;
    localparam int CH_IDX_W = 3;
    localparam int CNT_W    = 4;

    localparam logic [SAMPLE_W-1:0] TH_LOW_RST  = 8'h00;
    localparam logic [SAMPLE_W-1:0] TH_HIGH_RST = 8'hFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] limit);
        return (cnt >= limit) ? limit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/vital_threshold_scheduler_if.sv
// Sample/config/alarm bus between the sensor front end, the alarm logic and the scheduler.
interface vital_threshold_scheduler_if
    import vital_threshold_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4
) ();

    logic                         sampleValid;
    logic [NUM_CH*SAMPLE_W-1:0]   sampleVec;
    logic                         cfgWe;
    logic [CH_IDX_W-1:0]          cfgCh;
    logic [SAMPLE_W-1:0]          cfgLow;
    logic [SAMPLE_W-1:0]          cfgHigh;
    logic [NUM_CH-1:0]            alarmAck;
    logic                         busy;
    logic                         scanDone;
    logic [NUM_CH-1:0]            lowFlag;
    logic [NUM_CH-1:0]            highFlag;
    logic [NUM_CH-1:0]            alarm;

    modport master (
        output sampleValid, sampleVec, cfgWe, cfgCh, cfgLow, cfgHigh, alarmAck,
        input  busy, scanDone, lowFlag, highFlag, alarm
    );

    modport slave (
        input  sampleValid, sampleVec, cfgWe, cfgCh, cfgLow, cfgHigh, alarmAck,
        output busy, scanDone, lowFlag, highFlag, alarm
    );

endinterface

// File: rtl/vital_threshold_bank.sv
// Per-channel low/high threshold register file; writes are accepted only while the scheduler is idle.
module vital_threshold_bank
    import vital_threshold_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                busy_i,
    input  logic                wr_en_i,
    input  logic [CH_IDX_W-1:0] wr_ch_i,
    input  logic [SAMPLE_W-1:0] wr_low_i,
    input  logic [SAMPLE_W-1:0] wr_high_i,
    input  logic [CH_IDX_W-1:0] rd_ch_i,
    output logic [SAMPLE_W-1:0] rd_low_o,
    output logic [SAMPLE_W-1:0] rd_high_o
);

    logic [SAMPLE_W-1:0] low_q  [NUM_CH];
    logic [SAMPLE_W-1:0] high_q [NUM_CH];

    // Threshold storage; an index outside the channel range matches no entry and is dropped.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                low_q[i]  <= TH_LOW_RST;
                high_q[i] <= TH_HIGH_RST;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en_i && !busy_i && (wr_ch_i == CH_IDX_W'(i))) begin
                    low_q[i]  <= wr_low_i;
                    high_q[i] <= wr_high_i;
                end
            end
        end
    end

    // Read mux for the channel whose operands are loaded next.
    always_comb begin
        rd_low_o  = TH_LOW_RST;
        rd_high_o = TH_HIGH_RST;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_low_o  = (rd_ch_i == CH_IDX_W'(i)) ? low_q[i]  : rd_low_o;
            rd_high_o = (rd_ch_i == CH_IDX_W'(i)) ? high_q[i] : rd_high_o;
        end
    end

endmodule

// File: rtl/vital_threshold_scheduler.sv
// Time-shares one external magnitude comparator across NUM_CH vital-sign channels,
// debouncing out-of-range readings into latched per-channel alarms.
module vital_threshold_scheduler
    import vital_threshold_scheduler_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PERSIST = 3
) (
    input  logic                   clock,
    input  logic                   resetN,
    vital_threshold_scheduler_if.slave bus,
    output logic [SAMPLE_W-1:0]    cmpP,
    output logic [SAMPLE_W-1:0]    cmpQ,
    input  logic                   cmpLess,
    input  logic                   cmpEqual,
    input  logic                   cmpGreater
);

    state_t                      state_q;
    logic [CH_IDX_W-1:0]         ch_q;
    logic [CH_IDX_W-1:0]         rd_ch_d;
    logic [NUM_CH*SAMPLE_W-1:0]  sample_q;
    logic [NUM_CH*SAMPLE_W-1:0]  sample_src_s;
    logic [SAMPLE_W-1:0]         next_sample_d;
    logic [SAMPLE_W-1:0]         th_low_s;
    logic [SAMPLE_W-1:0]         th_high_s;
    logic [SAMPLE_W-1:0]         cmp_p_q;
    logic [SAMPLE_W-1:0]         cmp_q_q;
    logic [NUM_CH-1:0]           low_viol_q;
    logic [NUM_CH-1:0]           high_viol_q;
    logic [NUM_CH-1:0]           viol_s;
    logic [NUM_CH-1:0]           low_flag_q;
    logic [NUM_CH-1:0]           high_flag_q;
    logic [NUM_CH-1:0]           alarm_q;
    logic [CNT_W-1:0]            cnt_q     [NUM_CH];
    logic [CNT_W-1:0]            cnt_inc_s [NUM_CH];
    logic                        busy_q;
    logic                        scan_done_q;
    logic                        last_ch_s;

    assign last_ch_s    = (ch_q == CH_IDX_W'(NUM_CH - 1));
    assign sample_src_s = (state_q == ST_IDLE) ? bus.sampleVec : sample_q;
    assign viol_s       = low_viol_q | high_viol_q;

    vital_threshold_bank #(.NUM_CH(NUM_CH)) u_bank (
        .clock     (clock),
        .resetN    (resetN),
        .busy_i    (busy_q),
        .wr_en_i   (bus.cfgWe),
        .wr_ch_i   (bus.cfgCh),
        .wr_low_i  (bus.cfgLow),
        .wr_high_i (bus.cfgHigh),
        .rd_ch_i   (rd_ch_d),
        .rd_low_o  (th_low_s),
        .rd_high_o (th_high_s)
    );

    // Channel whose operands get loaded at the coming edge; never steps past the last channel.
    always_comb begin
        rd_ch_d = '0;
        case (state_q)
            ST_CMP_LO: rd_ch_d = ch_q;
            ST_CMP_HI: rd_ch_d = last_ch_s ? '0 : ch_q + CH_IDX_W'(1);
            default:   rd_ch_d = '0;
        endcase
    end

    // Sample byte for that channel plus the saturating counter candidates.
    always_comb begin
        next_sample_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            next_sample_d = (rd_ch_d == CH_IDX_W'(i)) ? sample_src_s[i*SAMPLE_W +: SAMPLE_W]
                                                      : next_sample_d;
            cnt_inc_s[i]  = sat_inc(cnt_q[i], CNT_W'(PERSIST));
        end
    end

    // Scan FSM: operands are registered one edge ahead so the comparator result is valid in-state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            sample_q    <= '0;
            cmp_p_q     <= '0;
            cmp_q_q     <= '0;
            low_viol_q  <= '0;
            high_viol_q <= '0;
            low_flag_q  <= '0;
            high_flag_q <= '0;
            alarm_q     <= '0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            scan_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.alarmAck[i] && (cnt_q[i] == CNT_W'(0))) begin
                    alarm_q[i] <= 1'b0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.sampleValid) begin
                        sample_q <= bus.sampleVec;
                        ch_q     <= '0;
                        cmp_p_q  <= next_sample_d;
                        cmp_q_q  <= th_low_s;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CMP_LO;
                    end
                end
                ST_CMP_LO: begin
                    // Equality with a threshold is in range even if the comparator glitches both bits.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == CH_IDX_W'(i)) begin
                            low_viol_q[i] <= cmpLess & ~cmpEqual;
                        end
                    end
                    cmp_q_q <= th_high_s;
                    state_q <= ST_CMP_HI;
                end
                ST_CMP_HI: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == CH_IDX_W'(i)) begin
                            high_viol_q[i] <= cmpGreater & ~cmpEqual;
                        end
                    end
                    if (last_ch_s) begin
                        cmp_p_q     <= '0;
                        cmp_q_q     <= '0;
                        scan_done_q <= 1'b1;
                        state_q     <= ST_COMMIT;
                    end else begin
                        ch_q    <= ch_q + CH_IDX_W'(1);
                        cmp_p_q <= next_sample_d;
                        cmp_q_q <= th_low_s;
                        state_q <= ST_CMP_LO;
                    end
                end
                ST_COMMIT: begin
                    low_flag_q  <= low_viol_q;
                    high_flag_q <= high_viol_q;
                    // Both bounds violated (low > high) still counts as one violating scan.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (viol_s[i]) begin
                            cnt_q[i] <= cnt_inc_s[i];
                            if (cnt_inc_s[i] == CNT_W'(PERSIST)) begin
                                alarm_q[i] <= 1'b1;
                            end
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmpP         = cmp_p_q;
    assign cmpQ         = cmp_q_q;
    assign bus.busy     = busy_q;
    assign bus.scanDone = scan_done_q;
    assign bus.lowFlag  = low_flag_q;
    assign bus.highFlag = high_flag_q;
    assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_vital_threshold_scheduler.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a randomized
// phase checked against an arithmetic model of thresholds, debounce counters and alarms.
module tb_vital_threshold_scheduler;

    localparam int NCH = 4;
    localparam int PER = 3;

    typedef struct {
        int         low;
        int         high;
        logic [7:0] smp;
        logic       exp_lo;
        logic       exp_hi;
    } vec_t;

    logic       clock  = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] cmpP, cmpQ;
    logic       cmpLess, cmpEqual, cmpGreater;

    int total = 0;
    int bad   = 0;

    int             m_lo  [NCH];
    int             m_hi  [NCH];
    int             m_cnt [NCH];
    logic [NCH-1:0] m_al, m_lf, m_hf;

    vital_threshold_scheduler_if #(.NUM_CH(NCH)) bus ();

    always #5 clock = ~clock;

    assign cmpLess    = (cmpP <  cmpQ);
    assign cmpEqual   = (cmpP == cmpQ);
    assign cmpGreater = (cmpP >  cmpQ);

    vital_threshold_scheduler #(.NUM_CH(NCH), .PERSIST(PER)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .bus        (bus),
        .cmpP       (cmpP),
        .cmpQ       (cmpQ),
        .cmpLess    (cmpLess),
        .cmpEqual   (cmpEqual),
        .cmpGreater (cmpGreater)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_lo[i] = 0; m_hi[i] = 255; m_cnt[i] = 0;
        end
        m_al = '0; m_lf = '0; m_hf = '0;
    endtask

    task automatic model_commit(input logic [NCH*8-1:0] vec, input logic [NCH-1:0] ack);
        for (int i = 0; i < NCH; i++) begin
            int  s;
            bit  lv, hv;
            s  = int'(vec[i*8 +: 8]);
            lv = (s < m_lo[i]);
            hv = (s > m_hi[i]);
            if (ack[i] && m_cnt[i] == 0) m_al[i] = 1'b0;
            m_lf[i] = lv;
            m_hf[i] = hv;
            if (lv || hv) begin
                m_cnt[i] = (m_cnt[i] < PER) ? m_cnt[i] + 1 : PER;
                if (m_cnt[i] == PER) m_al[i] = 1'b1;
            end else begin
                m_cnt[i] = 0;
            end
        end
    endtask

    task automatic model_post(input logic [NCH-1:0] ack);
        for (int i = 0; i < NCH; i++) begin
            if (ack[i] && m_cnt[i] == 0) m_al[i] = 1'b0;
        end
    endtask

    task automatic cfg(input int ch, input int lo, input int hi);
        @(negedge clock);
        bus.cfgWe   = 1'b1;
        bus.cfgCh   = 3'(ch);
        bus.cfgLow  = 8'(lo);
        bus.cfgHigh = 8'(hi);
        @(posedge clock);
        #1 bus.cfgWe = 1'b0;
        if (ch < NCH) begin
            m_lo[ch] = lo; m_hi[ch] = hi;
        end
    endtask

    // ack is held from the sampling edge until one edge after commit.
    task automatic scan(input logic [NCH*8-1:0] vec, input logic [NCH-1:0] ack,
                        output logic [NCH-1:0] a_c, output logic [NCH-1:0] a_p);
        int n;
        bit seen;
        @(negedge clock);
        bus.sampleVec   = vec;
        bus.sampleValid = 1'b1;
        bus.alarmAck    = ack;
        @(posedge clock);
        #1 bus.sampleValid = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                chk("cmpP_lo", 32'(cmpP), 32'(vec[7:0]));
                chk("cmpQ_lo", 32'(cmpQ), 32'(m_lo[0]));
            end
            if (n == 2) chk("cmpQ_hi", 32'(cmpQ), 32'(m_hi[0]));
            if (bus.scanDone) seen = 1;
        end
        chk("scan_latency", 32'(n), 32'd9);
        model_commit(vec, ack);
        @(negedge clock);
        chk("done_pulse", 32'(bus.scanDone), 32'd0);
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("lowFlag", 32'(bus.lowFlag), 32'(m_lf));
        chk("highFlag", 32'(bus.highFlag), 32'(m_hf));
        chk("alarm_commit", 32'(bus.alarm), 32'(m_al));
        a_c = bus.alarm;
        model_post(ack);
        @(negedge clock);
        chk("alarm_post", 32'(bus.alarm), 32'(m_al));
        a_p = bus.alarm;
        bus.alarmAck = '0;
    endtask

    initial begin
        vec_t           tbl [5];
        logic [NCH-1:0] a_c, a_p;
        logic [NCH*8-1:0] v;
        int             dones;

        tbl[0] = '{60, 100, 8'd59,  1'b1, 1'b0};
        tbl[1] = '{60, 100, 8'd60,  1'b0, 1'b0};
        tbl[2] = '{60, 100, 8'd100, 1'b0, 1'b0};
        tbl[3] = '{60, 100, 8'd101, 1'b0, 1'b1};
        tbl[4] = '{200, 100, 8'd150, 1'b1, 1'b1};

        bus.sampleValid = 1'b0; bus.sampleVec = '0; bus.cfgWe = 1'b0;
        bus.cfgCh = '0; bus.cfgLow = '0; bus.cfgHigh = '0; bus.alarmAck = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.scanDone), 32'd0);
        chk("rst_flags", 32'({bus.lowFlag, bus.highFlag}), 32'd0);
        chk("rst_alarm", 32'(bus.alarm), 32'd0);
        chk("rst_cmp", 32'({cmpP, cmpQ}), 32'd0);

        scan({8'h10, 8'h80, 8'hFF, 8'h00}, 4'h0, a_c, a_p);
        chk("dflt_flags", 32'({bus.lowFlag, bus.highFlag, bus.alarm}), 32'd0);

        for (int k = 0; k < 5; k++) begin
            cfg(0, tbl[k].low, tbl[k].high);
            scan({8'd80, 8'd80, 8'd80, tbl[k].smp}, 4'h0, a_c, a_p);
            chk("tbl_lo", 32'(bus.lowFlag[0]), 32'(tbl[k].exp_lo));
            chk("tbl_hi", 32'(bus.highFlag[0]), 32'(tbl[k].exp_hi));
        end
        cfg(0, 60, 100);

        cfg(1, 50, 200);
        for (int s = 1; s <= 4; s++) begin
            scan({8'd80, 8'd80, 8'd40, 8'd80}, 4'h0, a_c, a_p);
            chk("debounce_alarm1", 32'(a_c[1]), (s >= 3) ? 32'd1 : 32'd0);
        end
        scan({8'd80, 8'd80, 8'd40, 8'd80}, 4'b0010, a_c, a_p);
        chk("ack_sat_hold", 32'(a_p[1]), 32'd1);
        scan({8'd80, 8'd80, 8'd55, 8'd80}, 4'b0010, a_c, a_p);
        chk("ack_wait_commit", 32'(a_c[1]), 32'd1);
        chk("ack_clear_next", 32'(a_p[1]), 32'd0);

        cfg(2, 50, 200);
        scan({8'd80, 8'd40, 8'd80, 8'd80}, 4'h0, a_c, a_p);
        scan({8'd80, 8'd40, 8'd80, 8'd80}, 4'h0, a_c, a_p);
        scan({8'd80, 8'd40, 8'd80, 8'd80}, 4'b0100, a_c, a_p);
        chk("collide_set_wins", 32'(a_c[2]), 32'd1);
        chk("collide_post", 32'(a_p[2]), 32'd1);

        v = {8'd80, 8'd80, 8'd80, 8'd80};
        @(negedge clock);
        bus.sampleVec = v; bus.sampleValid = 1'b1;
        @(posedge clock);
        #1 bus.sampleValid = 1'b0;
        dones = 0;
        repeat (2) @(negedge clock);
        chk("busy_mid", 32'(bus.busy), 32'd1);
        bus.cfgWe = 1'b1; bus.cfgCh = 3'd0; bus.cfgLow = 8'd60; bus.cfgHigh = 8'd20;
        bus.sampleValid = 1'b1;
        @(posedge clock);
        #1 bus.cfgWe = 1'b0; bus.sampleValid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (bus.scanDone) dones++;
        end
        chk("busy_one_done", 32'(dones), 32'd1);
        model_commit(v, 4'h0);
        model_post(4'h0);
        chk("busy_flags", 32'({bus.lowFlag, bus.highFlag}), 32'({m_lf, m_hf}));
        scan({8'd80, 8'd80, 8'd80, 8'd90}, 4'h0, a_c, a_p);
        chk("busy_cfg_dropped", 32'(bus.highFlag[0]), 32'd0);

        cfg(3, 100, 255);
        scan({8'd10, 8'd80, 8'd80, 8'd80}, 4'h0, a_c, a_p);
        scan({8'd10, 8'd80, 8'd80, 8'd80}, 4'h0, a_c, a_p);
        @(negedge clock);
        bus.sampleVec = {8'd10, 8'd80, 8'd80, 8'd10}; bus.sampleValid = 1'b1;
        @(posedge clock);
        #1 bus.sampleValid = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b0;
        model_reset();
        dones = 0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.scanDone) dones++;
        end
        chk("rst_mid_no_done", 32'(dones), 32'd0);
        chk("rst_mid_flags", 32'({bus.lowFlag, bus.highFlag}), 32'd0);
        chk("rst_mid_alarm", 32'(bus.alarm), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        scan({8'd10, 8'd80, 8'd80, 8'd10}, 4'h0, a_c, a_p);
        chk("rst_mid_thresh", 32'({bus.lowFlag, bus.highFlag}), 32'd0);
        cfg(3, 100, 255);
        scan({8'd10, 8'd80, 8'd80, 8'd80}, 4'h0, a_c, a_p);
        chk("rst_mid_cnt", 32'(a_c[3]), 32'd0);

        for (int r = 0; r < 30; r++) begin
            logic [NCH-1:0] ack;
            if ($urandom_range(0, 2) == 0) begin
                int lo, hi;
                lo = $urandom_range(0, 150);
                hi = lo + $urandom_range(0, 105);
                if ($urandom_range(0, 4) == 0) cfg($urandom_range(0, 7), hi, lo);
                else                           cfg($urandom_range(0, 7), lo, hi);
            end
            ack = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            v   = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            scan(v, ack, a_c, a_p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
